// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle; slave is the hazard unit, master the datapath.
// HU_PERF_CNT_EN adds the stall counter (HU_StallCnt) to the bundle.
interface hazard_unit_if
`ifdef HU_PERF_CNT_EN
    #(parameter int CNT_WIDTH = 32)
`endif
    ;
    logic [4:0] HU_RsD;
    logic [4:0] HU_RtD;
    logic       HU_BranchD;
    logic       HU_PCSrcD;
    logic [4:0] HU_RsE;
    logic [4:0] HU_RtE;
    logic [4:0] HU_WriteRegE;
    logic       HU_RegWriteE;
    logic       HU_MemToRegE;
    logic [4:0] HU_WriteRegM;
    logic       HU_RegWriteM;
    logic       HU_MemToRegM;
    logic       HU_MemReqM;
    logic       HU_MemReadyM;
    logic [4:0] HU_WriteRegW;
    logic       HU_RegWriteW;
    logic [1:0] HU_ForwardAE;
    logic [1:0] HU_ForwardBE;
    logic       HU_ForwardAD;
    logic       HU_ForwardBD;
    logic       HU_StallF;
    logic       HU_StallD;
    logic       HU_StallE;
    logic       HU_StallM;
    logic       HU_StallW;
    logic       HU_FlushD;
    logic       HU_FlushE;
    logic       HU_MemErr;
`ifdef HU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] HU_StallCnt;
`endif

    modport slave (
        input  HU_RsD, HU_RtD, HU_BranchD, HU_PCSrcD, HU_RsE, HU_RtE,
               HU_WriteRegE, HU_RegWriteE, HU_MemToRegE, HU_WriteRegM,
               HU_RegWriteM, HU_MemToRegM, HU_MemReqM, HU_MemReadyM,
               HU_WriteRegW, HU_RegWriteW,
        output HU_ForwardAE, HU_ForwardBE, HU_ForwardAD, HU_ForwardBD,
               HU_StallF, HU_StallD, HU_StallE, HU_StallM, HU_StallW,
               HU_FlushD, HU_FlushE, HU_MemErr
`ifdef HU_PERF_CNT_EN
        , output HU_StallCnt
`endif
    );

    modport master (
        output HU_RsD, HU_RtD, HU_BranchD, HU_PCSrcD, HU_RsE, HU_RtE,
               HU_WriteRegE, HU_RegWriteE, HU_MemToRegE, HU_WriteRegM,
               HU_RegWriteM, HU_MemToRegM, HU_MemReqM, HU_MemReadyM,
               HU_WriteRegW, HU_RegWriteW,
        input  HU_ForwardAE, HU_ForwardBE, HU_ForwardAD, HU_ForwardBD,
               HU_StallF, HU_StallD, HU_StallE, HU_StallM, HU_StallW,
               HU_FlushD, HU_FlushE, HU_MemErr
`ifdef HU_PERF_CNT_EN
        , input HU_StallCnt
`endif
    );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding/stall/flush controller for the 5-stage MIPS with a memory-wait freeze FSM and timeout watchdog.
// Optional stall-cycle counter enabled by defining HU_PERF_CNT_EN.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic         HU_CLK,
    input  logic         HU_RST,
    hazard_unit_if.slave hu
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(MEM_TIMEOUT);
    localparam logic [TW-1:0] CNT_ONE_C = {{(TW-1){1'b0}}, 1'b1};

    if (MEM_TIMEOUT < 2 || CNT_WIDTH < 1) begin : g_param_check
        $error("hazard_unit: MEM_TIMEOUT must be >= 2 and CNT_WIDTH >= 1");
    end

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1
    } mem_state_t;

    mem_state_t    r_state;
    mem_state_t    w_state_nxt;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;
    logic          r_mem_err;
    logic          w_err_set;

    logic [1:0] w_fwd_ae;
    logic [1:0] w_fwd_be;
    logic       w_fwd_ad;
    logic       w_fwd_bd;
    logic       w_lwstall;
    logic       w_brstall;
    logic       w_memstall;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_stall_e;
    logic       w_stall_m;
    logic       w_stall_w;
    logic       w_flush_d;
    logic       w_flush_e;

    // $0 is hardwired, so a write to it never creates a dependency
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // Execute-stage operand forwarding, memory stage takes priority over writeback
    always_comb begin
        w_fwd_ae = 2'b00;
        w_fwd_be = 2'b00;
        if (hu.HU_RegWriteM && reg_match(hu.HU_WriteRegM, hu.HU_RsE)) begin
            w_fwd_ae = 2'b10;
        end else if (hu.HU_RegWriteW && reg_match(hu.HU_WriteRegW, hu.HU_RsE)) begin
            w_fwd_ae = 2'b01;
        end else begin
            w_fwd_ae = 2'b00;
        end
        if (hu.HU_RegWriteM && reg_match(hu.HU_WriteRegM, hu.HU_RtE)) begin
            w_fwd_be = 2'b10;
        end else if (hu.HU_RegWriteW && reg_match(hu.HU_WriteRegW, hu.HU_RtE)) begin
            w_fwd_be = 2'b01;
        end else begin
            w_fwd_be = 2'b00;
        end
    end

    assign w_fwd_ad = hu.HU_RegWriteM && reg_match(hu.HU_WriteRegM, hu.HU_RsD);
    assign w_fwd_bd = hu.HU_RegWriteM && reg_match(hu.HU_WriteRegM, hu.HU_RtD);

    assign w_lwstall = hu.HU_MemToRegE && hu.HU_RegWriteE &&
                       (reg_match(hu.HU_WriteRegE, hu.HU_RsD) || reg_match(hu.HU_WriteRegE, hu.HU_RtD));
    assign w_brstall = hu.HU_BranchD &&
                       ((hu.HU_RegWriteE &&
                         (reg_match(hu.HU_WriteRegE, hu.HU_RsD) || reg_match(hu.HU_WriteRegE, hu.HU_RtD))) ||
                        (hu.HU_MemToRegM &&
                         (reg_match(hu.HU_WriteRegM, hu.HU_RsD) || reg_match(hu.HU_WriteRegM, hu.HU_RtD))));

    // The cycle that hits the timeout is let through so the pipeline cannot deadlock
    assign w_memstall = hu.HU_MemReqM && !hu.HU_MemReadyM &&
                        !((r_state == MEM_WAIT) && (r_cnt == TIMEOUT_C));

    // Memory-wait FSM next state, wait counter and timeout detection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (hu.HU_MemReqM && !hu.HU_MemReadyM) begin
                    w_state_nxt = MEM_WAIT;
                    w_cnt_nxt   = CNT_ONE_C;
                end else begin
                    w_state_nxt = MEM_IDLE;
                end
            end
            MEM_WAIT: begin
                if (hu.HU_MemReadyM) begin
                    w_state_nxt = MEM_IDLE;
                    w_cnt_nxt   = {TW{1'b0}};
                end else if (r_cnt == TIMEOUT_C) begin
                    w_state_nxt = MEM_IDLE;
                    w_cnt_nxt   = {TW{1'b0}};
                    w_err_set   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE_C;
                end
            end
            default: begin
                w_state_nxt = MEM_IDLE;
                w_cnt_nxt   = {TW{1'b0}};
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag
    always_ff @(posedge HU_CLK) begin
        if (!HU_RST) begin
            r_state   <= MEM_IDLE;
            r_cnt     <= {TW{1'b0}};
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mem_err <= r_mem_err | w_err_set;
        end
    end

    // Stall/flush resolution: reset forces a bubble everywhere, memory freeze beats everything else
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_stall_w = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (!HU_RST) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_memstall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_stall_w = 1'b1;
        end else begin
            w_stall_f = w_lwstall | w_brstall;
            w_stall_d = w_lwstall | w_brstall;
            w_flush_e = w_lwstall | w_brstall;
            w_flush_d = hu.HU_PCSrcD & ~(w_lwstall | w_brstall);
        end
    end

    assign hu.HU_ForwardAE = HU_RST ? w_fwd_ae : 2'b00;
    assign hu.HU_ForwardBE = HU_RST ? w_fwd_be : 2'b00;
    assign hu.HU_ForwardAD = HU_RST & w_fwd_ad;
    assign hu.HU_ForwardBD = HU_RST & w_fwd_bd;
    assign hu.HU_StallF    = w_stall_f;
    assign hu.HU_StallD    = w_stall_d;
    assign hu.HU_StallE    = w_stall_e;
    assign hu.HU_StallM    = w_stall_m;
    assign hu.HU_StallW    = w_stall_w;
    assign hu.HU_FlushD    = w_flush_d;
    assign hu.HU_FlushE    = w_flush_e;
    assign hu.HU_MemErr    = r_mem_err;

`ifdef HU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Saturating count of fetch-stall cycles
    always_ff @(posedge HU_CLK) begin
        if (!HU_RST) begin
            r_stall_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_stall_f && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign hu.HU_StallCnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (MEM_TIMEOUT=4): expected output vectors queued per cycle, compared at negedge.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if hu ();
    hazard_unit #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (.HU_CLK(clk), .HU_RST(rst_n), .hu(hu));

    // vector: {FwdAE[2], FwdBE[2], FwdAD, FwdBD, Stall F,D,E,M,W, FlushD, FlushE, MemErr}
    logic [13:0] sb_q[$];
    logic [13:0] got;
    logic [13:0] want;
    string       tag;
    int          n_cmp = 0;
    int          n_err = 0;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_FD   = 5'b11000;
    localparam logic [4:0] S_ALL  = 5'b11111;

    function automatic logic [13:0] ev(input logic [1:0] fae, input logic [1:0] fbe, input logic fad,
                                       input logic fbd, input logic [4:0] st, input logic fd,
                                       input logic fe, input logic err);
        return {fae, fbe, fad, fbd, st, fd, fe, err};
    endfunction

    function automatic logic [13:0] obs();
        return {hu.HU_ForwardAE, hu.HU_ForwardBE, hu.HU_ForwardAD, hu.HU_ForwardBD,
                hu.HU_StallF, hu.HU_StallD, hu.HU_StallE, hu.HU_StallM, hu.HU_StallW,
                hu.HU_FlushD, hu.HU_FlushE, hu.HU_MemErr};
    endfunction

    task automatic clr_in();
        hu.HU_RsD = 5'd0; hu.HU_RtD = 5'd0; hu.HU_BranchD = 1'b0; hu.HU_PCSrcD = 1'b0;
        hu.HU_RsE = 5'd0; hu.HU_RtE = 5'd0; hu.HU_WriteRegE = 5'd0;
        hu.HU_RegWriteE = 1'b0; hu.HU_MemToRegE = 1'b0;
        hu.HU_WriteRegM = 5'd0; hu.HU_RegWriteM = 1'b0; hu.HU_MemToRegM = 1'b0;
        hu.HU_MemReqM = 1'b0; hu.HU_MemReadyM = 1'b0;
        hu.HU_WriteRegW = 5'd0; hu.HU_RegWriteW = 1'b0;
    endtask

    task automatic lw_use_in();
        hu.HU_MemToRegE = 1'b1; hu.HU_RegWriteE = 1'b1; hu.HU_WriteRegE = 5'd2; hu.HU_RsD = 5'd2;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0, 1: begin
                    tag = "reset_forced"; rst_n = 1'b0;
                    hu.HU_RegWriteM = 1'b1; hu.HU_WriteRegM = 5'd3; hu.HU_RsE = 5'd3;
                    lw_use_in(); hu.HU_PCSrcD = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b1, 1'b1, 1'b0));
                end
                default: begin
                    tag = "reset_release"; rst_n = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0));
                end
            endcase
            @(negedge clk); got = obs(); want = sb_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL %s step %0d: got %b want %b", tag, i, got, want); end
        end
    endtask

    task automatic test_forward();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0: begin tag = "fwd_m";
                    hu.HU_RegWriteM = 1'b1; hu.HU_WriteRegM = 5'd3; hu.HU_RsE = 5'd3;
                    sb_q.push_back(ev(2'b10, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                1: begin tag = "fwd_w";
                    hu.HU_RegWriteW = 1'b1; hu.HU_WriteRegW = 5'd3; hu.HU_RsE = 5'd3;
                    sb_q.push_back(ev(2'b01, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                2: begin tag = "fwd_m_prio";
                    hu.HU_RegWriteM = 1'b1; hu.HU_WriteRegM = 5'd3;
                    hu.HU_RegWriteW = 1'b1; hu.HU_WriteRegW = 5'd3; hu.HU_RsE = 5'd3;
                    sb_q.push_back(ev(2'b10, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                3: begin tag = "fwd_be_w";
                    hu.HU_RegWriteW = 1'b1; hu.HU_WriteRegW = 5'd5; hu.HU_RtE = 5'd5; hu.HU_RsE = 5'd6;
                    sb_q.push_back(ev(2'b00, 2'b01, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                4: begin tag = "fwd_split";
                    hu.HU_RegWriteM = 1'b1; hu.HU_WriteRegM = 5'd8; hu.HU_RtE = 5'd8;
                    hu.HU_RegWriteW = 1'b1; hu.HU_WriteRegW = 5'd9; hu.HU_RsE = 5'd9;
                    sb_q.push_back(ev(2'b01, 2'b10, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                5: begin tag = "fwd_reg0";
                    hu.HU_RegWriteM = 1'b1; hu.HU_RegWriteW = 1'b1; hu.HU_RegWriteE = 1'b1;
                    hu.HU_MemToRegE = 1'b1; hu.HU_BranchD = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                6: begin tag = "fwd_no_regwrite";
                    hu.HU_WriteRegM = 5'd3; hu.HU_RsE = 5'd3; hu.HU_WriteRegW = 5'd4; hu.HU_RtE = 5'd4;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                default: begin tag = "fwd_decode";
                    hu.HU_RegWriteM = 1'b1; hu.HU_WriteRegM = 5'd7; hu.HU_RsD = 5'd7; hu.HU_RtD = 5'd7;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b1, 1'b1, S_NONE, 1'b0, 1'b0, 1'b0)); end
            endcase
            @(negedge clk); got = obs(); want = sb_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL %s step %0d: got %b want %b", tag, i, got, want); end
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0: begin tag = "lw_stall"; lw_use_in();
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_FD, 1'b0, 1'b1, 1'b0)); end
                1: begin tag = "lw_in_m";
                    hu.HU_RegWriteM = 1'b1; hu.HU_MemToRegM = 1'b1; hu.HU_WriteRegM = 5'd2; hu.HU_RsD = 5'd2;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b1, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                2: begin tag = "lw_fwd_w";
                    hu.HU_RegWriteW = 1'b1; hu.HU_WriteRegW = 5'd2; hu.HU_RsE = 5'd2;
                    sb_q.push_back(ev(2'b01, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                default: begin tag = "lw_no_regwrite";
                    hu.HU_MemToRegE = 1'b1; hu.HU_WriteRegE = 5'd2; hu.HU_RtD = 5'd2;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
            endcase
            @(negedge clk); got = obs(); want = sb_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL %s step %0d: got %b want %b", tag, i, got, want); end
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0: begin tag = "br_stall_e";
                    hu.HU_BranchD = 1'b1; hu.HU_PCSrcD = 1'b1; hu.HU_RsD = 5'd4;
                    hu.HU_RegWriteE = 1'b1; hu.HU_WriteRegE = 5'd4;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_FD, 1'b0, 1'b1, 1'b0)); end
                1: begin tag = "br_fwd_flush";
                    hu.HU_BranchD = 1'b1; hu.HU_PCSrcD = 1'b1; hu.HU_RsD = 5'd4;
                    hu.HU_RegWriteM = 1'b1; hu.HU_WriteRegM = 5'd4;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b1, 1'b0, S_NONE, 1'b1, 1'b0, 1'b0)); end
                2: begin tag = "br_stall_ld_m";
                    hu.HU_BranchD = 1'b1; hu.HU_RtD = 5'd6;
                    hu.HU_RegWriteM = 1'b1; hu.HU_MemToRegM = 1'b1; hu.HU_WriteRegM = 5'd6;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b1, S_FD, 1'b0, 1'b1, 1'b0)); end
                default: begin tag = "br_taken_clean";
                    hu.HU_BranchD = 1'b1; hu.HU_PCSrcD = 1'b1; hu.HU_RsD = 5'd8; hu.HU_RtD = 5'd9;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b1, 1'b0, 1'b0)); end
            endcase
            @(negedge clk); got = obs(); want = sb_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL %s step %0d: got %b want %b", tag, i, got, want); end
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0, 1, 2: begin tag = "mem_freeze";
                    hu.HU_MemReqM = 1'b1; lw_use_in(); hu.HU_PCSrcD = 1'b1;
                    hu.HU_RegWriteM = 1'b1; hu.HU_WriteRegM = 5'd9; hu.HU_RsE = 5'd9;
                    sb_q.push_back(ev(2'b10, 2'b00, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b0)); end
                3: begin tag = "mem_release_lw";
                    hu.HU_MemReqM = 1'b1; hu.HU_MemReadyM = 1'b1; lw_use_in(); hu.HU_PCSrcD = 1'b1;
                    hu.HU_RegWriteM = 1'b1; hu.HU_WriteRegM = 5'd9; hu.HU_RsE = 5'd9;
                    sb_q.push_back(ev(2'b10, 2'b00, 1'b0, 1'b0, S_FD, 1'b0, 1'b1, 1'b0)); end
                4: begin tag = "mem_back_to_back";
                    hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b0)); end
                5: begin tag = "mem_ready";
                    hu.HU_MemReqM = 1'b1; hu.HU_MemReadyM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                default: begin tag = "mem_idle";
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
            endcase
            @(negedge clk); got = obs(); want = sb_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL %s step %0d: got %b want %b", tag, i, got, want); end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0, 1, 2, 3: begin tag = "to_wait"; hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b0)); end
                4: begin tag = "to_release"; hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                5: begin tag = "to_err_rewait"; hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b1)); end
                6: begin tag = "to_ready"; hu.HU_MemReadyM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b1)); end
                default: begin tag = "to_err_sticky";
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b1)); end
            endcase
            @(negedge clk); got = obs(); want = sb_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL %s step %0d: got %b want %b", tag, i, got, want); end
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; clr_in(); rst_n = 1'b1;
            case (i)
                0, 1: begin tag = "rw_wait"; hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b1)); end
                2: begin tag = "rw_rst_assert"; rst_n = 1'b0; hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b1, 1'b1, 1'b1)); end
                3: begin tag = "rw_rst_held"; rst_n = 1'b0; hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b1, 1'b1, 1'b0)); end
                4, 5, 6, 7: begin tag = "rw_fresh_wait"; hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b0)); end
                8: begin tag = "rw_fresh_timeout"; hu.HU_MemReqM = 1'b1;
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b0)); end
                default: begin tag = "rw_err_again";
                    sb_q.push_back(ev(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, 1'b0, 1'b0, 1'b1)); end
            endcase
            @(negedge clk); got = obs(); want = sb_q.pop_front(); n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL %s step %0d: got %b want %b", tag, i, got, want); end
`ifdef HU_PERF_CNT_EN
            if (i == 3) begin
                n_cmp++;
                if (hu.HU_StallCnt !== 32'd0) begin
                    n_err++; $display("FAIL stall_cnt_reset: got %0d want 0", hu.HU_StallCnt);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if (hu.HU_StallCnt !== 32'd4) begin
                    n_err++; $display("FAIL stall_cnt_count: got %0d want 4", hu.HU_StallCnt);
                end
            end
`endif
        end
    endtask

    initial begin
        clr_in();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
